// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller (master) and its datapath (slave).
// With PERF_CNT_EN defined the bundle also carries the CycleCount/InstRet counters.
interface multicycle_controller_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         Opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               Zero;
    logic               Neg;
    logic               MemReady;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ImmSrc;
    logic [2:0]         ALUControl;
    logic               Illegal;
    logic [STATE_W-1:0] State;
`ifdef PERF_CNT_EN
    logic [31:0]        CycleCount;
    logic [31:0]        InstRet;
`endif

    modport master (
        input  Opcode, funct3, funct7, Zero, Neg, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
        output ImmSrc, ALUControl, Illegal, State
`ifdef PERF_CNT_EN
        , output CycleCount, InstRet
`endif
    );

    modport slave (
        output Opcode, funct3, funct7, Zero, Neg, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
        input  ImmSrc, ALUControl, Illegal, State
`ifdef PERF_CNT_EN
        , input CycleCount, InstRet
`endif
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory stalls.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    multicycle_controller_if.master ctrl
);
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StLink     = 4'd12,
        StLui      = 4'd13,
        StIllegal  = 4'd14
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    state_e     state_q, state_d;
    logic [2:0] alu_op;
    logic       alu_ok;
    logic       br_ok;
    logic       br_taken;
    logic       is_r;
    logic       r_f7_ok;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type needs funct7 == 0 except for sub; I-ALU ignores funct7.
    assign is_r    = (ctrl.Opcode == OpR);
    assign r_f7_ok = !is_r || (ctrl.funct7 == 7'b0000000);

    always_comb begin
        alu_op = AluAdd;
        alu_ok = 1'b1;
        case (ctrl.funct3)
            3'b000: begin
                if (is_r && ctrl.funct7 == 7'b0100000) begin
                    alu_op = AluSub;
                end else begin
                    alu_ok = r_f7_ok;
                end
            end
            3'b111: begin
                alu_op = AluAnd;
                alu_ok = r_f7_ok;
            end
            3'b110: begin
                alu_op = AluOr;
                alu_ok = r_f7_ok;
            end
            3'b100: begin
                alu_op = AluXor;
                alu_ok = r_f7_ok;
            end
            3'b010: begin
                alu_op = AluSlt;
                alu_ok = r_f7_ok;
            end
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (ctrl.funct3)
            3'b000:  br_taken = ctrl.Zero;
            3'b001:  br_taken = !ctrl.Zero;
            3'b100:  br_taken = ctrl.Neg;
            3'b101:  br_taken = !ctrl.Neg;
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = ImmI;
        alu_control = AluAdd;
        unique case (state_q)
            StFetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ctrl.MemReady;
                pc_write   = ctrl.MemReady;
                if (ctrl.MemReady) state_d = StDecode;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (ctrl.Opcode == OpJal) ? ImmJ : ImmB;
                case (ctrl.Opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = alu_ok ? StExecR : StIllegal;
                    OpI:             state_d = alu_ok ? StExecI : StIllegal;
                    OpBranch:        state_d = br_ok ? StBranch : StIllegal;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (ctrl.Opcode == OpStore) ? ImmS : ImmI;
                state_d   = (ctrl.Opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (ctrl.MemReady) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ctrl.MemReady) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
                state_d     = StAluWb;
            end
            StExecI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a   = 2'b10;
                alu_control = AluSub;
                pc_write    = br_taken;
                state_d     = StFetch;
            end
            StJal: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = StLink;
            end
            StLink: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = StAluWb;
            end
            StLui: begin
                imm_src    = ImmU;
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StIllegal: state_d = StIllegal;
            default:   state_d = StIllegal;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held, even in FETCH.
    assign ctrl.PCWrite    = pc_write & rst_n;
    assign ctrl.IRWrite    = ir_write & rst_n;
    assign ctrl.MemWrite   = mem_write & rst_n;
    assign ctrl.RegWrite   = reg_write & rst_n;
    assign ctrl.AdrSrc     = adr_src;
    assign ctrl.ResultSrc  = result_src;
    assign ctrl.ALUSrcA    = alu_src_a;
    assign ctrl.ALUSrcB    = alu_src_b;
    assign ctrl.ImmSrc     = imm_src;
    assign ctrl.ALUControl = alu_control;
    assign ctrl.Illegal    = (state_q == StIllegal);
    assign ctrl.State      = STATE_W'(state_q);

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (state_d == StFetch && state_q != StFetch) instret_q <= instret_q + 32'd1;
        end
    end

    assign ctrl.CycleCount = cycle_q;
    assign ctrl.InstRet    = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed state-sequence table, hand-written
// corner cases, and random instructions checked against a per-instruction summary model.
module tb_multicycle_controller;
    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpSys    = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n;

    multicycle_controller_if #(.STATE_W(STATE_W)) bus ();
    multicycle_controller #(.STATE_W(STATE_W)) dut (.clk(clk), .rst_n(rst_n), .ctrl(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_model = 0;
    int ret_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-instruction summary derived from the ISA-level rules, not from the state machine.
    typedef struct {
        bit         legal;
        int         cycles;
        bit         mem;
        bit         store;
        int         regw;
        logic [1:0] rsrc;
        int         pcw;
        bit         is_alu;
        logic [2:0] alu;
    } exp_t;

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic zero, input logic neg);
        exp_t e;
        e = '{legal: 1'b1, cycles: 0, mem: 1'b0, store: 1'b0, regw: 0, rsrc: 2'b00, pcw: 1,
              is_alu: 1'b0, alu: 3'b000};
        case (op)
            OpR, OpI: begin
                e.cycles = 4;
                e.regw   = 1;
                e.is_alu = 1'b1;
                case (f3)
                    3'b000:  e.alu = (op == OpR && f7 == 7'h20) ? 3'b001 : 3'b000;
                    3'b111:  e.alu = 3'b010;
                    3'b110:  e.alu = 3'b011;
                    3'b100:  e.alu = 3'b100;
                    3'b010:  e.alu = 3'b101;
                    default: e.legal = 1'b0;
                endcase
                if (op == OpR && f7 != 7'h00 && !(f3 == 3'b000 && f7 == 7'h20)) e.legal = 1'b0;
            end
            OpLoad: begin
                e.cycles = 5;
                e.mem    = 1'b1;
                e.regw   = 1;
                e.rsrc   = 2'b01;
            end
            OpStore: begin
                e.cycles = 4;
                e.mem    = 1'b1;
                e.store  = 1'b1;
            end
            OpBranch: begin
                e.cycles = 3;
                case (f3)
                    3'b000:  e.pcw += int'(zero);
                    3'b001:  e.pcw += int'(!zero);
                    3'b100:  e.pcw += int'(neg);
                    3'b101:  e.pcw += int'(!neg);
                    default: e.legal = 1'b0;
                endcase
            end
            OpJal, OpJalr: begin
                e.cycles = (op == OpJal) ? 4 : 5;
                e.regw   = 1;
                e.pcw    = 2;
            end
            OpLui: begin
                e.cycles = 3;
                e.regw   = 1;
                e.rsrc   = 2'b11;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    // Entry and exit at posedge+1 with the DUT expected to be in FETCH on entry.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic zero, input logic neg,
                             input int fs, input int ms, input bit perf);
        exp_t e;
        int n, regw, pcw, irw, mw, adr, ill;
        logic [1:0] rs;
        logic [2:0] alu_seen;
        logic mr;
        e = model(op, f3, f7, zero, neg);
        n = e.legal ? e.cycles + fs + (e.mem ? ms : 0) : fs + 2;
        regw = 0; pcw = 0; irw = 0; mw = 0; adr = 0; ill = 0;
        rs = 2'b00; alu_seen = 3'b000;
        bus.Opcode = op; bus.funct3 = f3; bus.funct7 = f7; bus.Zero = zero; bus.Neg = neg;
        for (int k = 0; k < n; k++) begin
            if (k <= fs) mr = (k == fs);
            else if (e.mem && k >= fs + 3) mr = (k >= fs + 3 + ms);
            else mr = 1'($urandom_range(0, 1));
            bus.MemReady = mr;
            @(negedge clk);
            if (bus.RegWrite) begin
                regw++;
                rs = bus.ResultSrc;
            end
            pcw += int'(bus.PCWrite);
            irw += int'(bus.IRWrite);
            mw  += int'(bus.MemWrite);
            adr += int'(bus.AdrSrc);
            ill += int'(bus.Illegal);
            if (k == fs + 2) alu_seen = bus.ALUControl;
            @(posedge clk);
            #1;
        end
        cyc_model += n;
        if (e.legal) begin
            ret_model++;
            check({name, " end_state"}, bus.State, 0);
            check({name, " regwrite_cnt"}, regw, e.regw);
            check({name, " pcwrite_cnt"}, pcw, e.pcw);
            check({name, " irwrite_cnt"}, irw, 1);
            check({name, " memwrite_cnt"}, mw, e.store ? ms + 1 : 0);
            check({name, " adrsrc_cnt"}, adr, e.mem ? ms + 1 : 0);
            check({name, " illegal_cnt"}, ill, 0);
            if (e.regw != 0) check({name, " resultsrc_wb"}, rs, e.rsrc);
            if (e.is_alu) check({name, " alucontrol"}, alu_seen, e.alu);
        end else begin
            check({name, " illegal_state"}, bus.State, 14);
            check({name, " illegal_flag"}, bus.Illegal, 1);
            check({name, " illegal_writes"}, regw + mw, 0);
        end
`ifdef PERF_CNT_EN
        if (perf) begin
            check({name, " cyclecount"}, bus.CycleCount, cyc_model);
            check({name, " instret"}, bus.InstRet, ret_model);
        end
`else
        if (perf) cyc_model = cyc_model + 0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.MemReady = 1'b0;
        bus.Opcode = 7'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0; bus.Zero = 1'b0; bus.Neg = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc_model = 1;
        ret_model = 0;
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         len;
        logic [23:0] st;
        logic [2:0] alu2;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"add",  OpR,      3'b000, 7'h00, 4, 24'h0168,  3'b000};
        vecs[1] = '{"sub",  OpR,      3'b000, 7'h20, 4, 24'h0168,  3'b001};
        vecs[2] = '{"xor",  OpR,      3'b100, 7'h00, 4, 24'h0168,  3'b100};
        vecs[3] = '{"addi", OpI,      3'b000, 7'h55, 4, 24'h0178,  3'b000};
        vecs[4] = '{"lw",   OpLoad,   3'b010, 7'h00, 5, 24'h01234, 3'b000};
        vecs[5] = '{"sw",   OpStore,  3'b010, 7'h00, 4, 24'h0125,  3'b000};
        vecs[6] = '{"beq",  OpBranch, 3'b000, 7'h00, 3, 24'h019,   3'b001};
        vecs[7] = '{"jal",  OpJal,    3'b000, 7'h00, 4, 24'h01a8,  3'b000};
        vecs[8] = '{"jalr", OpJalr,   3'b000, 7'h00, 5, 24'h01bc8, 3'b000};
        vecs[9] = '{"lui",  OpLui,    3'b000, 7'h00, 3, 24'h01d,   3'b000};

        do_reset();
        check("reset state", bus.State, 0);
        check("reset illegal", bus.Illegal, 0);

        // Directed state sequences with memory always ready.
        foreach (vecs[i]) begin
            bus.Opcode = vecs[i].op; bus.funct3 = vecs[i].f3; bus.funct7 = vecs[i].f7;
            bus.MemReady = 1'b1;
            for (int k = 0; k < vecs[i].len; k++) begin
                @(negedge clk);
                check({vecs[i].name, " state"}, bus.State,
                      32'((vecs[i].st >> (4 * (vecs[i].len - 1 - k))) & 24'hf));
                if (k == 2) check({vecs[i].name, " alu"}, bus.ALUControl, vecs[i].alu2);
                if (vecs[i].name == "add")
                    check("add regwrite", bus.RegWrite, (k == 3) ? 1 : 0);
                @(posedge clk);
                #1;
            end
            check({vecs[i].name, " back_to_fetch"}, bus.State, 0);
        end

        // Load with two stall cycles in MEMREAD, and branch decisions.
        run_instr("lw_stall", OpLoad, 3'b010, 7'h00, 1'b0, 1'b0, 0, 2, 1'b0);
        run_instr("beq_z1", OpBranch, 3'b000, 7'h00, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr("bne_z1", OpBranch, 3'b001, 7'h00, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr("blt_n1", OpBranch, 3'b100, 7'h00, 1'b0, 1'b1, 0, 0, 1'b0);

        // jalr control details per cycle.
        bus.Opcode = OpJalr; bus.funct3 = 3'b000; bus.funct7 = 7'h00; bus.MemReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) check("jalr pc/result", {bus.PCWrite, bus.ResultSrc}, 3'b110);
            if (k == 3) check("link srcs", {bus.ALUSrcA, bus.ALUSrcB}, 4'b0110);
            if (k == 4) check("jalr wb", bus.RegWrite, 1);
            @(posedge clk);
            #1;
        end

        // Illegal opcode is absorbing until reset.
        run_instr("ecall", OpSys, 3'b000, 7'h00, 1'b0, 1'b0, 1, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bus.MemReady = 1'($urandom_range(0, 1));
            bus.Opcode = 7'($urandom);
            @(negedge clk);
            check("illegal hold", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                                   bus.Illegal, bus.State}, {5'b00001, 4'd14});
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("illegal reset", {bus.Illegal, bus.State}, 5'b0_0000);
        do_reset();

        // Reset dropped while a store waits in MEMWRITE.
        bus.Opcode = OpStore; bus.funct3 = 3'b010; bus.MemReady = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.MemReady = 1'b0;
        @(negedge clk);
        check("sw memwrite before reset", {bus.MemWrite, bus.State}, {1'b1, 4'd5});
        bus.MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset kills writes", {bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite}, 0);
        check("reset to fetch", bus.State, 0);
`ifdef PERF_CNT_EN
        check("reset counters", {bus.CycleCount, bus.InstRet}, 64'h0);
`endif
        @(posedge clk);
        bus.MemReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("fetch after release", {bus.State, bus.MemWrite}, 5'b0000_0);

        // Random instruction stream against the summary model.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            logic [6:0] op, f7;
            logic [2:0] f3;
            int cls;
            cls = $urandom_range(0, 19);
            f7  = 7'h00;
            f3  = 3'($urandom);
            case (cls)
                0, 1, 2: begin
                    op = OpR;
                    if ($urandom_range(0, 3) == 0) f7 = 7'h20;
                    else if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
                end
                3, 4, 5:   op = OpI;
                6, 7:      begin op = OpLoad; f3 = 3'b010; end
                8, 9:      begin op = OpStore; f3 = 3'b010; end
                10, 11, 12: op = OpBranch;
                13, 14:    op = OpJal;
                15, 16:    op = OpJalr;
                17, 18:    op = OpLui;
                default:   op = ($urandom_range(0, 1) == 0) ? OpSys : 7'b0001111;
            endcase
            f7 = (op == OpI) ? 7'($urandom) : f7;
            run_instr($sformatf("rand%0d", t), op, f3, f7, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
            if (bus.State == 4'd14) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
